rf_sync_regfile: RTL and testbench

- Configuration register file that consumes the SPI peripheral's memory interface (addr/we/wdata/wmask/rdata) and holds the DVS core configuration in the system clock domain.
- Synchronizes the SCK-domain write strobe into clk and applies byte-masked writes.
- Returns read data combinationally to the SPI peripheral.
- Exposes all registers as a flat config bus, plus a read-only status/write-count word.

---
 rtl/rf_sync_regfile.sv | 113 +++++++++++
 tb/tb_rf_sync_regfile.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_sync_regfile.sv
// Configuration register file fed by the SPI peripheral's memory port.
// The SCK-domain write strobe is synchronised into clk and edge-detected,
// so each spi_we high period causes exactly one byte-masked write. The top
// register is read-only and holds {status_q, wr_cnt}. Reads are combinational.
module rf_sync_regfile #(
  parameter int                  RF_AWIDTH = 3,
  parameter int                  RF_WIDTH  = 32,
  parameter int                  RF_MASK   = RF_WIDTH / 8,
  parameter logic [RF_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 spi_we,
  input  logic [RF_AWIDTH-1:0]                 spi_addr,
  input  logic [RF_WIDTH-1:0]                  spi_wdata,
  input  logic [RF_MASK-1:0]                   spi_wmask,
  output logic [RF_WIDTH-1:0]                  spi_rdata,
  input  logic [RF_WIDTH-9:0]                  status_i,
  output logic [(1<<RF_AWIDTH)*RF_WIDTH-1:0]   cfg_o,
  output logic                                 cfg_upd_o,
  output logic [RF_AWIDTH-1:0]                 cfg_upd_idx_o,
  output logic                                 ro_err_o
);

  localparam int                   NUM_REGS = 1 << RF_AWIDTH;
  localparam int                   RO_IDX   = NUM_REGS - 1;
  localparam logic [RF_AWIDTH-1:0] RO_ADDR  = RF_AWIDTH'(RO_IDX);

  logic                 r_s1, r_s2, r_s3;
  logic                 w_wr_stb;
  logic                 w_ro_hit;
  logic [RF_WIDTH-1:0]  r_regs [NUM_REGS-1];
  logic [RF_WIDTH-9:0]  r_status;
  logic [7:0]           r_wr_cnt;
  logic                 r_upd;
  logic [RF_AWIDTH-1:0] r_upd_idx;
  logic                 r_ro_err;
  logic [RF_WIDTH-1:0]  w_words [NUM_REGS];

  // s1/s2 resynchronise spi_we; s3 delays s2 so only its rising edge writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= spi_we;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_wr_stb = r_s2 & ~r_s3;
  assign w_ro_hit = (spi_addr == RO_ADDR);

  // RW array: byte-masked update of the addressed register on the strobe.
  // Address/data are sampled directly; the SPI side holds them while spi_we is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS - 1; i++) r_regs[i] <= RESET_VAL;
    end else if (w_wr_stb) begin
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        if (spi_addr == RF_AWIDTH'(i)) begin
          for (int b = 0; b < RF_MASK; b++) begin
            if (spi_wmask[b]) r_regs[i][8*b +: 8] <= spi_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  // Status sampling, write counter, update pulse and sticky RO-write flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status  <= '0;
      r_wr_cnt  <= '0;
      r_upd     <= 1'b0;
      r_upd_idx <= '0;
      r_ro_err  <= 1'b0;
    end else begin
      r_status <= status_i;
      r_upd    <= 1'b0;
      if (w_wr_stb) begin
        if (w_ro_hit) begin
          r_ro_err <= 1'b1;
        end else begin
          r_wr_cnt  <= r_wr_cnt + 8'd1;
          r_upd     <= 1'b1;
          r_upd_idx <= spi_addr;
        end
      end
    end
  end

  // Full register image, RO word in the top slot.
  always_comb begin
    for (int i = 0; i < NUM_REGS - 1; i++) w_words[i] = r_regs[i];
    w_words[RO_IDX] = {r_status, r_wr_cnt};
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_cfg
      assign cfg_o[gi*RF_WIDTH +: RF_WIDTH] = w_words[gi];
    end
  endgenerate

  assign spi_rdata     = w_words[spi_addr];
  assign cfg_upd_o     = r_upd;
  assign cfg_upd_idx_o = r_upd_idx;
  assign ro_err_o      = r_ro_err;

endmodule

// File: tb/tb_rf_sync_regfile.sv
// Directed plus randomised checks of rf_sync_regfile against a word-level model.
module tb_rf_sync_regfile;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         spi_we;
  logic [2:0]   spi_addr;
  logic [31:0]  spi_wdata;
  logic [3:0]   spi_wmask;
  logic [31:0]  spi_rdata;
  logic [23:0]  status_i;
  logic [255:0] cfg_o;
  logic         cfg_upd_o;
  logic [2:0]   cfg_upd_idx_o;
  logic         ro_err_o;

  int checks   = 0;
  int failures = 0;

  // model state
  logic [31:0] m_reg [7];
  logic [7:0]  m_cnt;
  logic        m_err;
  logic [23:0] m_status;

  rf_sync_regfile dut (
    .clk(clk), .rst_n(rst_n), .spi_we(spi_we), .spi_addr(spi_addr),
    .spi_wdata(spi_wdata), .spi_wmask(spi_wmask), .spi_rdata(spi_rdata),
    .status_i(status_i), .cfg_o(cfg_o), .cfg_upd_o(cfg_upd_o),
    .cfg_upd_idx_o(cfg_upd_idx_o), .ro_err_o(ro_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] exp_img();
    logic [255:0] v;
    for (int i = 0; i < 7; i++) v[i*32 +: 32] = m_reg[i];
    v[255:224] = {m_status, m_cnt};
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 7; i++) m_reg[i] = 32'h0;
    m_cnt    = 8'd0;
    m_err    = 1'b0;
    m_status = 24'h0;
  endtask

  task automatic model_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] bm;
    bm = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    if (a == 3'd7) m_err = 1'b1;
    else begin
      m_reg[a] = (m_reg[a] & ~bm) | (d & bm);
      m_cnt    = m_cnt + 8'd1;
    end
  endtask

  // Drive one write (spi_we high for `hold` clk, low for `gap` clk) and check
  // that the image changes at the third edge, with exactly one update pulse.
  task automatic write_op(input logic [2:0] a, input logic [31:0] d, input logic [3:0] m,
                          input logic [23:0] st, input int hold, input int gap);
    logic [255:0] pre, post;
    logic [2:0]   idx;
    int           upd_n, first;
    spi_addr = a; spi_wdata = d; spi_wmask = m; status_i = st; spi_we = 1'b1;
    m_status = st;
    pre = exp_img();
    model_write(a, d, m);
    post = exp_img();
    upd_n = 0; first = 0; idx = 3'd0;
    for (int n = 1; n <= hold + gap; n++) begin
      @(negedge clk);
      if (n == hold) spi_we = 1'b0;
      if (cfg_upd_o) begin
        upd_n++;
        if (first == 0) first = n;
        idx = cfg_upd_idx_o;
      end
      if (n == 2) chk("img_before_edge3", cfg_o, pre);
      if (n == 3) chk("img_at_edge3", cfg_o, post);
    end
    chk("upd_pulses", 256'(upd_n), (a == 3'd7) ? 256'd0 : 256'd1);
    if (a != 3'd7) begin
      chk("upd_cycle", 256'(first), 256'd3);
      chk("upd_idx", 256'(idx), 256'(a));
    end
    chk("ro_err", 256'(ro_err_o), 256'(m_err));
    #1;
    chk("rdata_wr_addr", 256'(spi_rdata), 256'(post[a*32 +: 32]));
  endtask

  initial begin
    logic [255:0] img;
    logic [7:0]   cnt0;
    logic [2:0]   ra;
    int           bad, upd_n, first;

    // 1: reset state, then idle
    rst_n = 1'b0; spi_we = 1'b0; spi_addr = 3'd7; spi_wdata = '0; spi_wmask = '0;
    status_i = 24'h5A5A5A;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cfg", cfg_o, 256'd0);
    chk("rst_rdata7", 256'(spi_rdata), 256'd0);
    chk("rst_ro_err", 256'(ro_err_o), 256'd0);
    chk("rst_upd", 256'({cfg_upd_o, cfg_upd_idx_o}), 256'd0);
    status_i = 24'h0;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (cfg_o !== 256'd0 || cfg_upd_o !== 1'b0 || ro_err_o !== 1'b0) bad++;
    end
    chk("idle_20clk_bad_cycles", 256'(bad), 256'd0);

    // 2: full word write
    write_op(3'd2, 32'hDEADBEEF, 4'hF, 24'h0, 6, 3);
    spi_addr = 3'd2; #1;
    chk("t2_rdata2", 256'(spi_rdata), 256'h0DEADBEEF);
    spi_addr = 3'd7; #1;
    chk("t2_wr_cnt", 256'(spi_rdata[7:0]), 256'd1);

    // 3: byte and halfword masks
    write_op(3'd3, 32'h11223344, 4'hF, 24'h0, 4, 3);
    write_op(3'd3, 32'hAAAAAAAA, 4'b0100, 24'h0, 4, 3);
    spi_addr = 3'd3; #1;
    chk("t3_byte2", 256'(spi_rdata), 256'h11AA3344);
    write_op(3'd3, 32'h0000BBCC, 4'b0011, 24'h0, 4, 3);
    spi_addr = 3'd3; #1;
    chk("t3_half", 256'(spi_rdata), 256'h11AABBCC);

    // 4: write to the RO register
    write_op(3'd7, 32'hFFFFFFFF, 4'hF, 24'h00ABCD, 5, 3);
    spi_addr = 3'd7; #1;
    chk("t4_ro_word", 256'(spi_rdata), 256'h00ABCD04);
    repeat (5) @(negedge clk);
    chk("t4_ro_err_sticky", 256'(ro_err_o), 256'd1);

    // 5a: stuck-high strobe gives one write
    write_op(3'd0, 32'h0BADF00D, 4'hF, 24'h000001, 100, 4);
    // 5b: 256 short pulses wrap the counter back to its start value
    cnt0 = m_cnt;
    for (int i = 0; i < 256; i++)
      write_op(3'($urandom_range(0, 6)), $urandom, 4'($urandom), 24'($urandom), 4, 2);
    spi_addr = 3'd7; #1;
    chk("t5_cnt_wrap", 256'(spi_rdata[7:0]), 256'(cnt0));

    // random mix including RO hits and odd hold/gap lengths
    for (int i = 0; i < 40; i++) begin
      write_op(3'($urandom_range(0, 7)), $urandom, 4'($urandom), 24'($urandom),
               $urandom_range(4, 9), $urandom_range(2, 5));
      ra = 3'($urandom_range(0, 7));
      spi_addr = ra; #1;
      img = exp_img();
      chk("rand_read", 256'(spi_rdata), 256'(img[ra*32 +: 32]));
    end

    // 6a: reset during sync aborts the write, clears immediately
    status_i = 24'h0;
    @(negedge clk);
    spi_addr = 3'd1; spi_wdata = 32'h12345678; spi_wmask = 4'hF; spi_we = 1'b1;
    @(negedge clk);
    rst_n = 1'b0; #1;
    model_reset();
    chk("t6_async_ro_err", 256'(ro_err_o), 256'd0);
    chk("t6_async_cfg", cfg_o, 256'd0);
    spi_we = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    upd_n = 0;
    repeat (10) begin
      @(negedge clk);
      if (cfg_upd_o) upd_n++;
    end
    chk("t6_no_write_upd", 256'(upd_n), 256'd0);
    chk("t6_no_write_cfg", cfg_o, exp_img());

    // 6b: spi_we already high at release -> one write at edge 3
    spi_addr = 3'd5; spi_wdata = 32'hCAFE0001; spi_wmask = 4'hF; spi_we = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    img = exp_img();
    model_write(3'd5, 32'hCAFE0001, 4'hF);
    upd_n = 0; first = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 5) spi_we = 1'b0;
      if (cfg_upd_o) begin upd_n++; if (first == 0) first = n; end
      if (n == 2) chk("t6_rel_before", cfg_o, img);
      if (n == 3) chk("t6_rel_write", cfg_o, exp_img());
    end
    chk("t6_rel_upd_n", 256'(upd_n), 256'd1);
    chk("t6_rel_upd_cycle", 256'(first), 256'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
